// File: rtl/alu_regfile_unit.sv
// alu_regfile_unit: sequenced ALU with internal register file.
// Command is fetched, executed and written back; done pulses after 3 cycles.
module alu_regfile_unit #(
  parameter int WIDTH = 32,
  parameter int REGS  = 8,
  parameter int AW    = $clog2(REGS),
  parameter int CMD_W = 3 + 3*AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CMD_W-1:0] command,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] y,
  output logic             O,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_EXEC, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [AW-1:0]    sa_q, sa_d;
  logic [AW-1:0]    sb_q, sb_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             o_q, o_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] regs_q [REGS];
  logic [WIDTH-1:0] regs_d [REGS];

  logic [WIDTH:0]   sum, diff, shl;
  logic [WIDTH-1:0] res;
  logic             res_c, res_o;

  // ALU: result and carry/overflow from the latched operands
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    shl   = {1'b0, a_q} << b_q[SW-1:0];
    res   = ld_q;
    res_c = 1'b0;
    res_o = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_o = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_o = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_SLT: res = {{(WIDTH-1){1'b0}},
                     $signed(a_q) < $signed(b_q)};
      OP_SHL: begin
        res   = shl[WIDTH-1:0];
        res_c = shl[WIDTH];
      end
      default: res = ld_q;
    endcase
  end

  // Sequencer next-state: latch, fetch, execute/writeback
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ld_d    = ld_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    o_d     = o_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    regs_d  = regs_q;
    unique case (state_q)
      S_FETCH: begin
        a_d     = regs_q[sa_q];
        b_d     = regs_q[sb_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        y_d           = res;
        o_d           = res_o;
        c_d           = res_c;
        z_d           = (res == '0);
        n_d           = res[WIDTH-1];
        regs_d[dst_q] = res;
        state_d       = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (run) begin
          op_d    = command[CMD_W-1 -: 3];
          dst_d   = command[3*AW-1 -: AW];
          sa_d    = command[2*AW-1 -: AW];
          sb_d    = command[AW-1:0];
          ld_d    = load_data;
          state_d = S_FETCH;
        end
      end
    endcase
    busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and register file update with sync reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      ld_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      o_q     <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ld_q    <= ld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      o_q     <= o_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rd_data = regs_q[rd_addr];
  assign y       = y_q;
  assign O       = o_q;
  assign C       = c_q;
  assign Z       = z_q;
  assign N       = n_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Directed bench for alu_regfile_unit: 32x8 default instance
// plus an 8-bit / 4-register instance with a small reference model.
module tb_alu_regfile_unit;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2,
                         OR_ = 3'd3, XOR_ = 3'd4, SLT = 3'd5,
                         SHL = 3'd6, LOAD = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [11:0] command;
  logic [31:0] load_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data, y;
  logic        O, C, Z, N, busy, done;

  logic        run2;
  logic [8:0]  command2;
  logic [7:0]  load_data2;
  logic [1:0]  rd_addr2;
  logic [7:0]  rd_data2, y2;
  logic        O2, C2, Z2, N2, busy2, done2;

  int n_cmp = 0;
  int n_err = 0;
  int dcount;
  int m [4];

  always #5 clk = ~clk;

  alu_regfile_unit dut (
    .clk(clk), .reset(reset), .run(run), .command(command),
    .load_data(load_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .y(y), .O(O), .C(C), .Z(Z), .N(N), .busy(busy), .done(done)
  );

  alu_regfile_unit #(.WIDTH(8), .REGS(4)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .command(command2),
    .load_data(load_data2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .y(y2), .O(O2), .C(C2), .Z(Z2), .N(N2), .busy(busy2),
    .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one command on the 32-bit unit and check the done timing
  task automatic do1(input logic [2:0] op, input logic [2:0] d,
                     input logic [2:0] a, input logic [2:0] b,
                     input logic [31:0] ld);
    @(negedge clk);
    run = 1'b1;
    command = {op, d, a, b};
    load_data = ld;
    rd_addr = d;
    @(posedge clk); #1;
    run = 1'b0;
    chk("c1_busy_done", 32'({busy, done}), 32'h2);
    @(posedge clk); #1;
    chk("c2_busy_done", 32'({busy, done}), 32'h2);
    @(posedge clk); #1;
    chk("c3_busy_done", 32'({busy, done}), 32'h1);
  endtask

  task automatic res1(input string tag, input logic [31:0] ey,
                      input logic [3:0] ef);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_ocZN"}, 32'({O, C, Z, N}), 32'(ef));
    chk({tag, "_rd"}, rd_data, ey);
  endtask

  function automatic int model(input int op, input int a,
                               input int b, input int ld);
    int sa, sb, r;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = a * (1 << (b % 8));
      default: r = ld;
    endcase
    return r & 255;
  endfunction

  task automatic do2(input int op, input int d, input int a,
                     input int b, input int ld);
    int e;
    e = model(op, m[a], m[b], ld);
    @(negedge clk);
    run2 = 1'b1;
    command2 = {3'(op), 2'(d), 2'(a), 2'(b)};
    load_data2 = 8'(ld);
    rd_addr2 = 2'(d);
    @(posedge clk); #1;
    run2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w8_done", 32'(done2), 32'h1);
    chk("w8_y", 32'(y2), 32'(e));
    m[d] = e;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    command = '0;
    load_data = '0;
    rd_addr = '0;
    run2 = 1'b0;
    command2 = '0;
    load_data2 = '0;
    rd_addr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y, 32'h0);
    chk("rst_flags", 32'({O, C, Z, N, busy, done}), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("rst_rd", rd_data, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    do1(LOAD, 1, 0, 0, 32'h7FFF_FFFF);
    res1("ld_r1", 32'h7FFF_FFFF, 4'h0);
    do1(LOAD, 2, 0, 0, 32'h1);
    res1("ld_r2", 32'h1, 4'h0);
    do1(ADD, 3, 1, 2, 32'h0);
    res1("add_ovf", 32'h8000_0000, 4'h9);
    do1(LOAD, 1, 0, 0, 32'h0);
    res1("ld_zero", 32'h0, 4'h2);
    do1(SUB, 4, 1, 2, 32'h0);
    res1("sub_borrow", 32'hFFFF_FFFF, 4'h5);
    do1(SUB, 5, 2, 2, 32'h0);
    res1("sub_zero", 32'h0, 4'h2);
    do1(LOAD, 1, 0, 0, 32'h8000_0001);
    res1("ld_neg", 32'h8000_0001, 4'h1);
    do1(SHL, 6, 1, 2, 32'h0);
    res1("shl_carry", 32'h2, 4'h4);
    do1(LOAD, 2, 0, 0, 32'h0);
    res1("ld_r2_0", 32'h0, 4'h2);
    do1(SHL, 6, 1, 2, 32'h0);
    res1("shl_zero", 32'h8000_0001, 4'h1);
    do1(SLT, 7, 1, 2, 32'h0);
    res1("slt_neg", 32'h1, 4'h0);
    do1(XOR_, 5, 1, 7, 32'h0);
    res1("xor", 32'h8000_0000, 4'h1);
    do1(OR_, 4, 6, 7, 32'h0);
    res1("or", 32'h8000_0001, 4'h1);
    do1(AND_, 3, 1, 6, 32'h0);
    res1("and", 32'h8000_0001, 4'h1);

    // run pulses in FETCH and EXEC are ignored
    do1(LOAD, 1, 0, 0, 32'h3);
    @(negedge clk);
    run = 1'b1;
    command = {ADD, 3'd1, 3'd1, 3'd1};
    rd_addr = 3'd1;
    @(posedge clk);
    @(negedge clk);
    command = {LOAD, 3'd7, 3'd0, 3'd0};
    load_data = 32'hDEAD;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    chk("busy_done", 32'(done), 32'h1);
    res1("alias_add", 32'h6, 4'h0);
    @(negedge clk);
    run = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("busy_extra_done", 32'(dcount), 32'h0);
    rd_addr = 3'd7;
    #1;
    chk("busy_ignored_r7", rd_data, 32'h1);
    chk("y_hold", y, 32'h6);

    // run held high: done every third cycle
    @(negedge clk);
    run = 1'b1;
    command = {ADD, 3'd1, 3'd1, 3'd1};
    rd_addr = 3'd1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      chk("cont_done", 32'(done), (i % 3 == 0) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    run = 1'b0;
    chk("cont_r1", rd_data, 32'd48);
    @(posedge clk); #1;
    chk("cont_idle", 32'({busy, done}), 32'h0);

    // reset in the middle of EXEC discards the command
    @(negedge clk);
    run = 1'b1;
    command = {LOAD, 3'd3, 3'd0, 3'd0};
    load_data = 32'h55;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_y", y, 32'h0);
    chk("mid_rst_flags", 32'({O, C, Z, N, busy, done}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_nodone", 32'(done), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("mid_rst_rd", rd_data, 32'h0);
    end

    // 8-bit / 4-register instance
    for (int i = 0; i < 4; i++) m[i] = 0;
    do2(7, 0, 0, 0, 8'h80);
    do2(7, 1, 0, 0, 8'h01);
    do2(5, 2, 0, 1, 0);
    chk("w8_slt", 32'(y2), 32'h1);
    for (int k = 0; k < 200; k++) begin
      do2(int'($urandom_range(7)), int'($urandom_range(3)),
          int'($urandom_range(3)), int'($urandom_range(3)),
          int'($urandom_range(255)));
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr2 = 2'(i);
      #1;
      chk("w8_rd", 32'(rd_data2), 32'(m[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_regfile_unit.md
# alu_regfile_unit

Parametrised successor to the single-shot ALU datapath. It combines a command decoder, an internal register file of REGS×WIDTH words, operand latches, the ALU and a flag register into one sequenced unit. A 12-bit (default) command names the op, the destination register and two source registers. The unit fetches the operands, executes, writes back, and signals completion with a one-cycle `done` pulse.

## Interface
- WIDTH, 32, datapath and register word width in bits (≥2)
- REGS, 8, number of registers (power of two, ≥2); AW = $clog2(REGS)
- CMD_W, 3+3*AW, command width (derived; do not override)

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  command strobe; sampled only in IDLE or DONE
- command  in  CMD_W  [CMD_W-1 -: 3] op, then dst, srcA, srcB (AW bits each, srcB in LSBs)
- load_data  in  WIDTH  immediate value for LOAD; sampled with the command
- rd_addr  in  AW  debug read address
- rd_data  out  WIDTH  combinational regs[rd_addr]
- y  out  WIDTH  last result, registered
- O, C, Z, N  out  1 each  overflow, carry/borrow, zero, negative flags, registered
- busy  out  1  high in FETCH and EXEC
- done  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE → FETCH → EXEC → DONE. DONE → FETCH if `run`=1, otherwise → IDLE.
- IDLE/DONE: on `run`=1, latch command fields and load_data into internal registers.
- FETCH: a_q ← regs[srcA], b_q ← regs[srcB].
- EXEC: compute result and flags. At the closing edge, y, O/C/Z/N and regs[dst] all update together.
- `run` in FETCH or EXEC is ignored, not queued.
- Ops (3-bit):
  - 000 ADD: a+b. C = carry out. O = signed overflow.
  - 001 SUB: a−b. C = borrow (1 iff a<b unsigned). O = signed overflow.
  - 010 AND, 011 OR, 100 XOR: C=O=0.
  - 101 SLT: result = 1 if $signed(a)<$signed(b), else 0. C=O=0.
  - 110 SHL: a << b[$clog2(WIDTH)-1:0]. C = last bit shifted out (0 when shift amount is 0). O=0.
  - 111 LOAD: result = latched load_data. Sources are ignored. C=O=0.
- For every op: Z = (result==0), N = result[WIDTH-1]. The result is truncated to WIDTH bits.
- Arithmetic uses a WIDTH+1-bit internal sum; signed overflow is computed from operand and result MSBs.
- dst may equal srcA/srcB. Operands are read in FETCH, before writeback, so the old values are used.
- Every register, including r0, is writable.

## Timing
- Reset (any state, including mid-operation): state=IDLE, all regs=0, y=0, O=C=Z=N=0, busy=0, done=0. An in-flight command is discarded with no writeback.
- `run` sampled at edge T0 → FETCH in cycle 1 → EXEC in cycle 2 → DONE in cycle 3.
- In cycle 3: done=1, and the new y, flags and regs[dst] are visible (rd_data reflects the write).
- Latency is 3 cycles. Peak throughput is one command per 3 cycles, achieved by asserting `run` during DONE.
- y and flags hold their values until the next EXEC completes.
- rd_data is combinational; a read of dst in cycle 3 returns the new value.

## Test plan
- Reset: assert reset 2 cycles mid-EXEC → all outputs 0, rd_data=0 for every address, no writeback observed.
- ADD overflow: LOAD r1=0x7FFFFFFF, LOAD r2=1, ADD r3,r1,r2 → y=0x80000000, O=1, N=1, C=0, Z=0, done exactly 3 cycles after run.
- SUB borrow/zero:
  - r1=0, r2=1, SUB r4,r1,r2 → y=0xFFFFFFFF, C=1, N=1, O=0.
  - SUB r5,r2,r2 → y=0, Z=1, C=0.
- SHL carry: r1=0x80000001, r2=1, SHL r6,r1,r2 → y=0x00000002, C=1. With r2=0 → y=0x80000001, C=0.
- Busy / back-to-back:
  - `run` pulsed in FETCH and EXEC → ignored; exactly one done pulse.
  - `run` held high continuously → done every 3rd cycle.
  - Aliasing ADD r1,r1,r1 with r1=3 → r1=6.
- Parametrisation: WIDTH=8, REGS=4 (CMD_W=9), SLT with 0x80 vs 0x01 → y=1. rd_data matches a reference model after 200 random commands.
